instr_mem_fetch: RTL and testbench
==================================

Name: instr_mem_fetch

Overview:
Parametrised instruction memory with a request/response fetch handshake, programmable wait states and a program-load write port. Sits between the IF-stage PC logic and the instruction register. It replaces a combinational ROM lookup with a timed, stallable fetch interface. Out-of-range and misaligned fetches return a NOP plus an error flag.

Parameters:
DATA_W, 32, instruction width in bits
DEPTH, 64, number of instruction words
ADDR_W, 32, byte-address width of fetch requests
WAIT_STATES, 1, extra cycles between request accept and response (0..15)
NOP_VALUE, 32'h0000_0000, instruction returned on error
INIT_FILE, "", hex file for $readmemh; empty means all words are zero

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
req_valid  in  1  fetch request present
req_ready  out  1  block can accept a request
req_addr  in  ADDR_W  byte address of the fetch
rsp_valid  out  1  response present
rsp_ready  in  1  consumer takes the response
rsp_instr  out  DATA_W  fetched instruction
rsp_err  out  1  response is an error (NOP substituted)
flush  in  1  synchronous abort of any pending fetch
load_en  in  1  program-load write strobe
load_addr  in  clog2(DEPTH)  word index for the load
load_data  in  DATA_W  word to write
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; rsp_valid=0, rsp_instr=0, rsp_err=0, wait counter=0. Memory contents are NOT cleared by reset.
- Word index = req_addr >> 2. Error if req_addr[1:0]!=0 or index >= DEPTH.
- FSM has three states: IDLE, WAIT, RESP.
- IDLE: req_ready = !load_en && !flush. Accept on req_valid && req_ready: latch index and the error bit. If WAIT_STATES=0, go to RESP. Otherwise load counter=WAIT_STATES and go to WAIT.
- WAIT: counter decrements each cycle. When the counter is 1, go to RESP. req_ready=0.
- Entry to RESP: rsp_instr is loaded with memory[index], or NOP_VALUE if error. rsp_err is set to the error bit. rsp_valid=1.
- Latency: rsp_valid rises WAIT_STATES+1 cycles after the accept edge.
- RESP: rsp_valid, rsp_instr and rsp_err are held stable until rsp_ready=1. On that handshake, go to IDLE and drive rsp_valid=0 on the next cycle. req_ready=0 in RESP, so there is no same-cycle re-accept. Throughput is one fetch per WAIT_STATES+2 cycles.
- flush=1, any state: next state is IDLE, rsp_valid=0 next cycle, and any pending response is discarded. flush takes priority over accept and over the rsp handshake.
- load_en: writes memory[load_addr] <= load_data at the clock edge, honoured only in IDLE. It is ignored (no write) in WAIT and RESP. load_addr >= DEPTH is ignored.
- Load and request in the same IDLE cycle: the load is performed and the request is not accepted (req_ready=0).
- Memory is read at RESP entry, so a load completed before accept is visible to that fetch.
- rsp_instr and rsp_err keep their last values after the handshake. Consumers qualify them with rsp_valid.

Test Plan:
- Reset, then load word 3 = 32'hE3A0_1005. Fetch addr 0x0C with WAIT_STATES=1 -> rsp_valid rises 2 cycles after accept, rsp_instr=32'hE3A0_1005, rsp_err=0.
- Fetch addr 0x0E (misaligned) -> rsp_instr=NOP_VALUE, rsp_err=1. Fetch addr 4*DEPTH -> same error response.
- Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid/rsp_instr stay stable and req_ready=0. Raise rsp_ready -> IDLE, rsp_valid=0 next cycle.
- Assert flush in the middle of WAIT -> no response ever appears and busy=0 next cycle. A following fetch of addr 0x00 returns the correct word.
- Assert load_en together with req_valid in IDLE -> write occurs and the request is not accepted. Next cycle the request is accepted and returns the newly written data. A load_en pulse during WAIT -> memory is unchanged.
- Assert rst low asynchronously during RESP -> rsp_valid=0 immediately and state=IDLE. Memory content written before the reset reads back unchanged. Repeat with WAIT_STATES=0 -> latency is 1 cycle.

Source files
------------

// File: rtl/instr_mem_fetch.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | instr_mem_fetch: instruction memory with request/response fetch,      |
// | programmable wait states and a program-load write port.               |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module instr_mem_fetch #(
   parameter int                DATA_W      = 32,
   parameter int                DEPTH       = 64,
   parameter int                ADDR_W      = 32,
   parameter int                WAIT_STATES = 1,
   parameter logic [DATA_W-1:0] NOP_VALUE   = 32'h0000_0000,
   parameter string             INIT_FILE   = "",
   localparam int               IDX_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_instr,
   output logic              rsp_err,
   input  logic              flush,
   input  logic              load_en,
   input  logic [IDX_W-1:0]  load_addr,
   input  logic [DATA_W-1:0] load_data,
   output logic              busy
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   localparam logic [3:0] WS_CNT = 4'(WAIT_STATES);

   logic [DATA_W-1:0] mem [DEPTH];

   state_t            state_q,     state_d;
   logic [3:0]        cnt_q,       cnt_d;
   logic [IDX_W-1:0]  idx_q,       idx_d;
   logic              err_q,       err_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0] rsp_instr_q, rsp_instr_d;
   logic              rsp_err_q,   rsp_err_d;

   logic [ADDR_W-1:0] req_word;
   logic [IDX_W-1:0]  req_idx;
   logic              req_err;
   logic [IDX_W-1:0]  rd_idx;
   logic              rd_err;
   logic              load_rsp;
   logic              mem_we;

   assign req_word = req_addr >> 2;
   assign req_idx  = req_word[IDX_W-1:0];
   assign req_err  = (req_addr[1:0] != 2'b00) || (req_word >= ADDR_W'(DEPTH));

   // Loads land only while idle so an in-flight fetch never sees a torn word.
   assign mem_we = load_en && (state_q == S_IDLE) &&
                   ({1'b0, load_addr} < (IDX_W + 1)'(DEPTH));

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[load_addr] <= load_data;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      err_d       = err_q;
      rsp_valid_d = rsp_valid_q;
      rsp_instr_d = rsp_instr_q;
      rsp_err_d   = rsp_err_q;
      rd_idx      = idx_q;
      rd_err      = err_q;
      load_rsp    = 1'b0;
      req_ready   = (state_q == S_IDLE) && !load_en && !flush;

      case (state_q)
         S_IDLE: begin
            if (req_valid && req_ready) begin
               idx_d = req_idx;
               err_d = req_err;
               if (WAIT_STATES == 0) begin
                  rd_idx   = req_idx;
                  rd_err   = req_err;
                  load_rsp = 1'b1;
                  state_d  = S_RESP;
               end else begin
                  cnt_d   = WS_CNT;
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               load_rsp = 1'b1;
               state_d  = S_RESP;
            end
         end
         S_RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Memory is sampled on RESP entry so the latest completed load is seen.
      if (load_rsp) begin
         rsp_valid_d = 1'b1;
         rsp_instr_d = rd_err ? NOP_VALUE : mem[rd_idx];
         rsp_err_d   = rd_err;
      end

      if (flush) begin
         state_d     = S_IDLE;
         cnt_d       = 4'd0;
         rsp_valid_d = 1'b0;
         rsp_instr_d = rsp_instr_q;
         rsp_err_d   = rsp_err_q;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= 4'd0;
         idx_q       <= '0;
         err_q       <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_instr_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         err_q       <= err_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_instr_q <= rsp_instr_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_instr = rsp_instr_q;
   assign rsp_err   = rsp_err_q;
   assign busy      = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_instr_mem_fetch.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_instr_mem_fetch: scoreboard bench, one instance with one wait      |
// | state and one with zero wait states. Rev 1.0                          |
// +-----------------------------------------------------------------------+
module tb_instr_mem_fetch;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid_a = 1'b0, req_valid_b = 1'b0;
   logic [31:0] req_addr = '0;
   logic        rsp_ready = 1'b0;
   logic        flush = 1'b0;
   logic        load_en = 1'b0;
   logic [5:0]  load_addr = '0;
   logic [31:0] load_data = '0;

   logic        req_ready_a, rsp_valid_a, rsp_err_a, busy_a;
   logic        req_ready_b, rsp_valid_b, rsp_err_b, busy_b;
   logic [31:0] rsp_instr_a, rsp_instr_b;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [31:0] instr;
      logic        err;
   } exp_t;
   exp_t q_a[$];
   exp_t q_b[$];

   always #5 clk = ~clk;

   instr_mem_fetch #(.WAIT_STATES(1)) dut_a (
      .clk(clk), .rst(rst), .req_valid(req_valid_a), .req_ready(req_ready_a),
      .req_addr(req_addr), .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready),
      .rsp_instr(rsp_instr_a), .rsp_err(rsp_err_a), .flush(flush),
      .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
      .busy(busy_a)
   );

   instr_mem_fetch #(.WAIT_STATES(0)) dut_b (
      .clk(clk), .rst(rst), .req_valid(req_valid_b), .req_ready(req_ready_b),
      .req_addr(req_addr), .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready),
      .rsp_instr(rsp_instr_b), .rsp_err(rsp_err_b), .flush(flush),
      .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
      .busy(busy_b)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic rv(input bit b);  return b ? rsp_valid_b : rsp_valid_a; endfunction
   function automatic logic rr(input bit b);  return b ? req_ready_b : req_ready_a; endfunction
   function automatic logic bz(input bit b);  return b ? busy_b      : busy_a;      endfunction
   function automatic logic [31:0] ri(input bit b); return b ? rsp_instr_b : rsp_instr_a; endfunction

   // Monitor: every accepted response is popped and checked against the queue.
   always @(negedge clk) begin
      exp_t e;
      if (rsp_valid_a && rsp_ready) begin
         if (q_a.size() == 0) chk("unexpected_rsp_a", 32'd1, 32'd0);
         else begin
            e = q_a.pop_front();
            chk("rsp_instr_a", rsp_instr_a, e.instr);
            chk("rsp_err_a", {31'd0, rsp_err_a}, {31'd0, e.err});
         end
      end
      if (rsp_valid_b && rsp_ready) begin
         if (q_b.size() == 0) chk("unexpected_rsp_b", 32'd1, 32'd0);
         else begin
            e = q_b.pop_front();
            chk("rsp_instr_b", rsp_instr_b, e.instr);
            chk("rsp_err_b", {31'd0, rsp_err_b}, {31'd0, e.err});
         end
      end
   end

   task automatic load(input logic [5:0] a, input logic [31:0] d);
      load_en   = 1'b1;
      load_addr = a;
      load_data = d;
      @(posedge clk); #1;
      load_en   = 1'b0;
   endtask

   task automatic fetch(input bit b, input logic [31:0] addr, input logic [31:0] exp_i,
                        input bit exp_e, input int hold, input bit load_in_wait);
      int n;
      logic [31:0] snap;
      exp_t e;
      req_addr  = addr;
      rsp_ready = 1'b0;
      if (b) req_valid_b = 1'b1; else req_valid_a = 1'b1;
      @(negedge clk);
      chk("req_ready_idle", {31'd0, rr(b)}, 32'd1);
      e.instr = exp_i;
      e.err   = exp_e;
      if (b) q_b.push_back(e); else q_a.push_back(e);
      n = 0;
      do begin
         @(posedge clk); #1;
         if (n == 0) begin
            req_valid_a = 1'b0;
            req_valid_b = 1'b0;
         end
         n++;
         load_en = load_in_wait && (n == 1);
         if (load_en) begin
            load_addr = 6'd5;
            load_data = 32'hDEAD_BEEF;
         end
      end while (!rv(b) && n < 20);
      load_en = 1'b0;
      chk(b ? "latency_b" : "latency_a", n, b ? 32'd1 : 32'd2);
      snap = ri(b);
      repeat (hold) begin
         @(negedge clk);
         chk("hold_valid", {31'd0, rv(b)}, 32'd1);
         chk("hold_instr", ri(b), snap);
         chk("hold_req_ready", {31'd0, rr(b)}, 32'd0);
         @(posedge clk); #1;
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      chk("valid_after_hs", {31'd0, rv(b)}, 32'd0);
      chk("busy_after_hs", {31'd0, bz(b)}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      @(negedge clk);
      chk("rst_rsp_valid", {31'd0, rsp_valid_a}, 32'd0);
      chk("rst_rsp_instr", rsp_instr_a, 32'd0);
      chk("rst_rsp_err", {31'd0, rsp_err_a}, 32'd0);
      chk("rst_busy", {31'd0, busy_a}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;

      load(6'd3, 32'hE3A0_1005);
      load(6'd0, 32'h0000_1111);

      fetch(0, 32'h0C, 32'hE3A0_1005, 1'b0, 0, 1'b0);
      fetch(0, 32'h0E, 32'h0000_0000, 1'b1, 0, 1'b0);
      fetch(0, 32'h100, 32'h0000_0000, 1'b1, 0, 1'b0);
      fetch(0, 32'h0C, 32'hE3A0_1005, 1'b0, 5, 1'b0);

      // Flush in WAIT: nothing may reach the monitor while rsp_ready is high.
      req_addr    = 32'h0C;
      req_valid_a = 1'b1;
      rsp_ready   = 1'b1;
      @(posedge clk); #1;
      req_valid_a = 1'b0;
      chk("busy_in_wait", {31'd0, busy_a}, 32'd1);
      flush = 1'b1;
      @(negedge clk);
      chk("req_ready_flush", {31'd0, req_ready_a}, 32'd0);
      @(posedge clk); #1;
      flush = 1'b0;
      chk("busy_after_flush", {31'd0, busy_a}, 32'd0);
      repeat (4) begin
         @(posedge clk); #1;
         chk("no_rsp_after_flush", {31'd0, rsp_valid_a}, 32'd0);
      end
      rsp_ready = 1'b0;
      fetch(0, 32'h00, 32'h0000_1111, 1'b0, 0, 1'b0);

      // Load and request together: load wins, request waits a cycle.
      load_en     = 1'b1;
      load_addr   = 6'd5;
      load_data   = 32'hA5A5_0005;
      req_addr    = 32'h14;
      req_valid_a = 1'b1;
      @(negedge clk);
      chk("req_ready_load", {31'd0, req_ready_a}, 32'd0);
      @(posedge clk); #1;
      load_en = 1'b0;
      chk("not_accepted_on_load", {31'd0, busy_a}, 32'd0);
      fetch(0, 32'h14, 32'hA5A5_0005, 1'b0, 0, 1'b0);
      fetch(0, 32'h14, 32'hA5A5_0005, 1'b0, 0, 1'b1);
      fetch(0, 32'h14, 32'hA5A5_0005, 1'b0, 0, 1'b0);

      // Asynchronous reset while a response is held.
      req_addr    = 32'h14;
      req_valid_a = 1'b1;
      rsp_ready   = 1'b0;
      @(posedge clk); #1;
      req_valid_a = 1'b0;
      @(posedge clk); #1;
      chk("resp_before_rst", {31'd0, rsp_valid_a}, 32'd1);
      #2 rst = 1'b0;
      #1;
      chk("async_rst_valid", {31'd0, rsp_valid_a}, 32'd0);
      chk("async_rst_busy", {31'd0, busy_a}, 32'd0);
      chk("async_rst_instr", rsp_instr_a, 32'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      fetch(0, 32'h0C, 32'hE3A0_1005, 1'b0, 0, 1'b0);
      fetch(0, 32'h14, 32'hA5A5_0005, 1'b0, 0, 1'b0);

      // Zero-wait-state instance; its word 5 took the load issued while it idled.
      fetch(1, 32'h0C, 32'hE3A0_1005, 1'b0, 2, 1'b0);
      fetch(1, 32'h00, 32'h0000_1111, 1'b0, 0, 1'b0);
      fetch(1, 32'h0E, 32'h0000_0000, 1'b1, 0, 1'b0);
      fetch(1, 32'h14, 32'hDEAD_BEEF, 1'b0, 0, 1'b0);

      repeat (2) @(posedge clk);
      chk("queue_a_drained", q_a.size(), 32'd0);
      chk("queue_b_drained", q_b.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
